// File: rtl/stopwatch_display_if.sv
// Counter-to-display bundle: binary time and mode lines in, multiplexed
// 7-segment drive out.
interface stopwatch_display_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adjust;
    logic       select;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output minutes, seconds, adjust, select,
        input  an, seg, dp
    );

    modport slave (
        input  minutes, seconds, adjust, select,
        output an, seg, dp
    );
endinterface

// File: rtl/stopwatch_display.sv
// Stopwatch display back end: per-frame binary-to-BCD conversion by repeated
// subtraction, 4-digit common-anode scan in MM.SS form, field blinking.
module stopwatch_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_display_if.slave disp
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         idx;
    logic               scan_wrap;
    logic               first_cyc;
    logic               frame_start;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    conv_state_t        state, state_nxt;
    logic               load, step, commit;
    logic [5:0]         m_rem, s_rem, m_rem_sub, s_rem_sub;
    logic [2:0]         m_tens, s_tens;
    logic [3:0]         digits [4];

    logic [3:0]         cur_digit;
    logic               blank;
    logic [3:0]         an_nxt;
    logic [6:0]         seg_nxt;
    logic               dp_nxt;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'b1000000;
            4'd1:    seg_lut = 7'b1111001;
            4'd2:    seg_lut = 7'b0100100;
            4'd3:    seg_lut = 7'b0110000;
            4'd4:    seg_lut = 7'b0011001;
            4'd5:    seg_lut = 7'b0010010;
            4'd6:    seg_lut = 7'b0000010;
            4'd7:    seg_lut = 7'b1111000;
            4'd8:    seg_lut = 7'b0000000;
            4'd9:    seg_lut = 7'b0010000;
            default: seg_lut = 7'b1111111;
        endcase
    endfunction

    assign scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    // A frame begins right after reset and whenever the scan returns to digit 0.
    assign frame_start = first_cyc | (scan_wrap & (idx == 2'd3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            first_cyc <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            first_cyc <= 1'b0;
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign m_rem_sub = (m_rem >= 6'd10) ? m_rem - 6'd10 : m_rem;
    assign s_rem_sub = (s_rem >= 6'd10) ? s_rem - 6'd10 : s_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                // Exit on the cycle whose subtraction leaves both remainders below ten.
                if ((m_rem_sub < 6'd10) && (s_rem_sub < 6'd10)) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  <= '0;
            s_rem  <= '0;
            m_tens <= '0;
            s_tens <= '0;
            // NOTE: the four digit registers are plain flops, not RAM, so they take the async reset.
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
        end else begin
            if (load) begin
                m_rem  <= disp.minutes;
                s_rem  <= disp.seconds;
                m_tens <= '0;
                s_tens <= '0;
            end else if (step) begin
                m_rem <= m_rem_sub;
                s_rem <= s_rem_sub;
                if (m_rem >= 6'd10) m_tens <= m_tens + 3'd1;
                if (s_rem >= 6'd10) s_tens <= s_tens + 3'd1;
            end
            if (commit) begin
                digits[3] <= {1'b0, m_tens};
                digits[2] <= m_rem[3:0];
                digits[1] <= {1'b0, s_tens};
                digits[0] <= s_rem[3:0];
            end
        end
    end

    always_comb begin
        cur_digit = digits[idx];
        // select = 0 owns idx 3/2 (idx[1] set); select = 1 owns idx 1/0.
        blank     = disp.adjust & ~blink_on & (disp.select ? ~idx[1] : idx[1]);
        an_nxt    = blank ? 4'b1111 : ~(4'b0001 << idx);
        seg_nxt   = blank ? 7'b1111111 : seg_lut(cur_digit);
        dp_nxt    = (idx != 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp.an  <= 4'b1111;
            disp.seg <= 7'b1111111;
            disp.dp  <= 1'b1;
        end else begin
            disp.an  <= an_nxt;
            disp.seg <= seg_nxt;
            disp.dp  <= dp_nxt;
        end
    end
endmodule
